// File: rtl/rect_seq_pkg.sv
// -----------------------------------------------------------------------------
// rect_seq_pkg
// Shared definitions for the rectangle scene sequencer:
//   - seq_state_t : sequencer state encoding (IDLE, FETCH, ISSUE, DWELL)
//   - entry layout helpers : total entry width and bit offsets of every field
//     of a script entry, derived from the coordinate/color/index widths.
// Entry layout, MSB to LSB:
//   {loop, last, enabled, index, color, x1, x2, y1, y2}
// -----------------------------------------------------------------------------
package rect_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_DWELL = 2'd3
   } seq_state_t;

   localparam int DEF_WIDTHBITS  = 10;
   localparam int DEF_HEIGHTBITS = 10;
   localparam int DEF_COLORBITS  = 8;
   localparam int DEF_RECTBITS   = 6;

   function automatic int entry_bits(input int wb, input int hb, input int cb, input int rb);
      return 3 + rb + cb + 2 * wb + 2 * hb;
   endfunction

   localparam int DEF_ENTRYBITS = entry_bits(DEF_WIDTHBITS, DEF_HEIGHTBITS,
                                             DEF_COLORBITS, DEF_RECTBITS);

   // Field offsets, lowest field first.
   function automatic int off_y2(input int wb, input int hb);
      return 0 * wb + 0 * hb;
   endfunction

   function automatic int off_y1(input int wb, input int hb);
      return 0 * wb + hb;
   endfunction

   function automatic int off_x2(input int wb, input int hb);
      return 0 * wb + 2 * hb;
   endfunction

   function automatic int off_x1(input int wb, input int hb);
      return wb + 2 * hb;
   endfunction

   function automatic int off_color(input int wb, input int hb);
      return 2 * wb + 2 * hb;
   endfunction

   function automatic int off_index(input int wb, input int hb, input int cb);
      return 2 * wb + 2 * hb + cb;
   endfunction

   function automatic int off_enabled(input int wb, input int hb, input int cb, input int rb);
      return 2 * wb + 2 * hb + cb + rb;
   endfunction

   function automatic int off_last(input int wb, input int hb, input int cb, input int rb);
      return 2 * wb + 2 * hb + cb + rb + 1;
   endfunction

   function automatic int off_loop(input int wb, input int hb, input int cb, input int rb);
      return 2 * wb + 2 * hb + cb + rb + 2;
   endfunction

endpackage

// File: rtl/rect_seq_table.sv
// -----------------------------------------------------------------------------
// rect_seq_table
// Simple dual-port script memory: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
// Contents are not reset.
// Ports:
//   clk            : clock
//   we, waddr, wdata : write strobe, address, data
//   re, raddr      : read enable and address (data appears next cycle)
//   rdata          : registered read data, held while re is low
// -----------------------------------------------------------------------------
module rect_seq_table #(
   parameter int ABITS = 6,
   parameter int DBITS = 57
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ABITS-1:0] waddr,
   input  logic [DBITS-1:0] wdata,
   input  logic             re,
   input  logic [ABITS-1:0] raddr,
   output logic [DBITS-1:0] rdata
);

   logic [DBITS-1:0] mem [0:(1 << ABITS) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/rect_scene_sequencer.sv
// -----------------------------------------------------------------------------
// rect_scene_sequencer
// Plays a host-written script of rectangle updates into the vga_pipeline
// rectangle-config port. Entries are fetched one at a time, issued as a
// single-cycle write when the pipeline is not stalled, and grouped into scenes
// terminated by a 'last' entry, after which the sequencer dwells for a
// programmable number of cycles and moves on (wrapping or looping to 0).
//
// Optional feature macro: RECT_SEQ_CLIP_EN
//   defined   : coordinates clamped to the screen and ordered (x1<=x2, y1<=y2)
//               combinationally in front of the output registers.
//   undefined : coordinates pass through verbatim.
//
// Ports:
//   clk, rst_b          : clock, synchronous active-low reset
//   run                 : playback enable (honoured in IDLE and at scene ends)
//   dwell               : hold cycles after a scene, sampled when it ends
//   tb_we/tb_addr/tb_wdata : script table write port
//   vg__stall           : blocks issue while high
//   st__conf_*, vg__rect_index : registered rectangle config fields
//   vg__rect_write      : one-cycle write pulse
//   busy                : sequencer is not idle
//   scene_done          : one-cycle pulse with the write of a 'last' entry
//   cur_addr            : address of the entry being fetched/issued
// -----------------------------------------------------------------------------
module rect_scene_sequencer
   import rect_seq_pkg::*;
#(
   parameter int WIDTHBITS  = 10,
   parameter int HEIGHTBITS = 10,
   parameter int COLORBITS  = 8,
   parameter int RECTBITS   = 6,
   parameter int TABBITS    = 6,
   parameter int DWELLBITS  = 27,
   parameter int WIDTH      = 800,
   parameter int HEIGHT     = 600,
   localparam int ENTRYBITS = entry_bits(WIDTHBITS, HEIGHTBITS, COLORBITS, RECTBITS)
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  run,
   input  logic [DWELLBITS-1:0]  dwell,
   input  logic                  tb_we,
   input  logic [TABBITS-1:0]    tb_addr,
   input  logic [ENTRYBITS-1:0]  tb_wdata,
   input  logic                  vg__stall,
   output logic [COLORBITS-1:0]  st__conf_color,
   output logic                  st__conf_enabled,
   output logic [WIDTHBITS-1:0]  st__conf_rect_x1,
   output logic [WIDTHBITS-1:0]  st__conf_rect_x2,
   output logic [HEIGHTBITS-1:0] st__conf_rect_y1,
   output logic [HEIGHTBITS-1:0] st__conf_rect_y2,
   output logic [RECTBITS-1:0]   vg__rect_index,
   output logic                  vg__rect_write,
   output logic                  busy,
   output logic                  scene_done,
   output logic [TABBITS-1:0]    cur_addr
);

`ifdef RECT_SEQ_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam int O_Y2    = off_y2(WIDTHBITS, HEIGHTBITS);
   localparam int O_Y1    = off_y1(WIDTHBITS, HEIGHTBITS);
   localparam int O_X2    = off_x2(WIDTHBITS, HEIGHTBITS);
   localparam int O_X1    = off_x1(WIDTHBITS, HEIGHTBITS);
   localparam int O_COLOR = off_color(WIDTHBITS, HEIGHTBITS);
   localparam int O_INDEX = off_index(WIDTHBITS, HEIGHTBITS, COLORBITS);
   localparam int O_EN    = off_enabled(WIDTHBITS, HEIGHTBITS, COLORBITS, RECTBITS);
   localparam int O_LAST  = off_last(WIDTHBITS, HEIGHTBITS, COLORBITS, RECTBITS);
   localparam int O_LOOP  = off_loop(WIDTHBITS, HEIGHTBITS, COLORBITS, RECTBITS);

   localparam logic [WIDTHBITS-1:0]  X_MAX = WIDTHBITS'(WIDTH - 1);
   localparam logic [HEIGHTBITS-1:0] Y_MAX = HEIGHTBITS'(HEIGHT - 1);

   seq_state_t             state;
   logic [DWELLBITS-1:0]   dwell_cnt;
   logic                   loop_q;
   logic                   fetch_en;
   logic [ENTRYBITS-1:0]   entry;

   logic                   e_loop;
   logic                   e_last;
   logic                   e_en;
   logic [RECTBITS-1:0]    e_idx;
   logic [COLORBITS-1:0]   e_color;
   logic [WIDTHBITS-1:0]   e_x1, e_x2, cx1, cx2, ox1, ox2;
   logic [HEIGHTBITS-1:0]  e_y1, e_y2, cy1, cy2, oy1, oy2;

   function automatic logic [WIDTHBITS-1:0] sat_x(input logic [WIDTHBITS-1:0] v);
      return (v > X_MAX) ? X_MAX : v;
   endfunction

   function automatic logic [HEIGHTBITS-1:0] sat_y(input logic [HEIGHTBITS-1:0] v);
      return (v > Y_MAX) ? Y_MAX : v;
   endfunction

   assign fetch_en = (state == S_FETCH);

   rect_seq_table #(
      .ABITS (TABBITS),
      .DBITS (ENTRYBITS)
   ) u_table (
      .clk   (clk),
      .we    (tb_we),
      .waddr (tb_addr),
      .wdata (tb_wdata),
      .re    (fetch_en),
      .raddr (cur_addr),
      .rdata (entry)
   );

   assign e_loop  = entry[O_LOOP];
   assign e_last  = entry[O_LAST];
   assign e_en    = entry[O_EN];
   assign e_idx   = entry[O_INDEX +: RECTBITS];
   assign e_color = entry[O_COLOR +: COLORBITS];
   assign e_x1    = entry[O_X1 +: WIDTHBITS];
   assign e_x2    = entry[O_X2 +: WIDTHBITS];
   assign e_y1    = entry[O_Y1 +: HEIGHTBITS];
   assign e_y2    = entry[O_Y2 +: HEIGHTBITS];

   // Optional clamp-then-order of the coordinates, folded into the issue cycle.
   always_comb begin
      cx1 = e_x1;
      cx2 = e_x2;
      cy1 = e_y1;
      cy2 = e_y2;
      if (CLIP_EN) begin
         cx1 = sat_x(e_x1);
         cx2 = sat_x(e_x2);
         cy1 = sat_y(e_y1);
         cy2 = sat_y(e_y2);
      end
      ox1 = cx1;
      ox2 = cx2;
      oy1 = cy1;
      oy2 = cy2;
      if (CLIP_EN && (cx1 > cx2)) begin
         ox1 = cx2;
         ox2 = cx1;
      end
      if (CLIP_EN && (cy1 > cy2)) begin
         oy1 = cy2;
         oy2 = cy1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state            <= S_IDLE;
         dwell_cnt        <= '0;
         loop_q           <= 1'b0;
         cur_addr         <= '0;
         busy             <= 1'b0;
         scene_done       <= 1'b0;
         vg__rect_write   <= 1'b0;
         vg__rect_index   <= '0;
         st__conf_color   <= '0;
         st__conf_enabled <= 1'b0;
         st__conf_rect_x1 <= '0;
         st__conf_rect_x2 <= '0;
         st__conf_rect_y1 <= '0;
         st__conf_rect_y2 <= '0;
      end else begin
         vg__rect_write <= 1'b0;
         scene_done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  state <= S_FETCH;
                  busy  <= 1'b1;
               end
            end
            S_FETCH: begin
               state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!vg__stall) begin
                  vg__rect_write   <= 1'b1;
                  vg__rect_index   <= e_idx;
                  st__conf_color   <= e_color;
                  st__conf_enabled <= e_en;
                  st__conf_rect_x1 <= ox1;
                  st__conf_rect_x2 <= ox2;
                  st__conf_rect_y1 <= oy1;
                  st__conf_rect_y2 <= oy2;
                  if (!e_last) begin
                     cur_addr <= cur_addr + TABBITS'(1);
                     state    <= S_FETCH;
                  end else begin
                     scene_done <= 1'b1;
                     loop_q     <= e_loop;
                     if (dwell == '0) begin
                        // Zero dwell: the scene boundary is taken right here.
                        cur_addr <= e_loop ? '0 : cur_addr + TABBITS'(1);
                        state    <= run ? S_FETCH : S_IDLE;
                        busy     <= run;
                     end else begin
                        dwell_cnt <= dwell;
                        state     <= S_DWELL;
                     end
                  end
               end
            end
            S_DWELL: begin
               // One cycle per dwell count; the final count is the exit cycle.
               if (dwell_cnt <= DWELLBITS'(1)) begin
                  dwell_cnt <= '0;
                  cur_addr  <= loop_q ? '0 : cur_addr + TABBITS'(1);
                  state     <= run ? S_FETCH : S_IDLE;
                  busy      <= run;
               end else begin
                  dwell_cnt <= dwell_cnt - DWELLBITS'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_scene_sequencer.sv
module tb_rect_scene_sequencer;

   typedef struct packed {
      logic       loop;
      logic       last;
      logic       en;
      logic [5:0] idx;
      logic [7:0] color;
      logic [9:0] x1;
      logic [9:0] x2;
      logic [9:0] y1;
      logic [9:0] y2;
   } ent_t;

   typedef struct {
      int cyc;
      int idx;
      int color;
      int en;
      int x1;
      int x2;
      int y1;
      int y2;
      int sd;
      int cur;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        run;
   logic [26:0] dwell;
   logic        tb_we;
   logic [1:0]  tb_addr;
   logic [56:0] tb_wdata;
   logic        vg__stall;
   logic [7:0]  st__conf_color;
   logic        st__conf_enabled;
   logic [9:0]  st__conf_rect_x1, st__conf_rect_x2, st__conf_rect_y1, st__conf_rect_y2;
   logic [5:0]  vg__rect_index;
   logic        vg__rect_write, busy, scene_done;
   logic [1:0]  cur_addr;

   rect_scene_sequencer #(.TABBITS(2)) dut (
      .clk              (clk),
      .rst_b            (rst_b),
      .run              (run),
      .dwell            (dwell),
      .tb_we            (tb_we),
      .tb_addr          (tb_addr),
      .tb_wdata         (tb_wdata),
      .vg__stall        (vg__stall),
      .st__conf_color   (st__conf_color),
      .st__conf_enabled (st__conf_enabled),
      .st__conf_rect_x1 (st__conf_rect_x1),
      .st__conf_rect_x2 (st__conf_rect_x2),
      .st__conf_rect_y1 (st__conf_rect_y1),
      .st__conf_rect_y2 (st__conf_rect_y2),
      .vg__rect_index   (vg__rect_index),
      .vg__rect_write   (vg__rect_write),
      .busy             (busy),
      .scene_done       (scene_done),
      .cur_addr         (cur_addr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit cmp_en = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at edge", nm, act, exp);
   endtask

   function automatic int mn(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int mx(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [56:0] mk(input bit lp, input bit ls, input bit en, input int idx,
                                      input int color, input int x1, input int x2,
                                      input int y1, input int y2);
      return {lp, ls, en, 6'(idx), 8'(color), 10'(x1), 10'(x2), 10'(y1), 10'(y2)};
   endfunction

   // ---------------- behavioural model (timeline of issue events) ----------
   int   edge_n = -1;
   logic [56:0] mtab [4];
   bit   m_active = 0, m_dwelling = 0, m_loop = 0;
   int   m_elig = 0, m_exit = 0, m_addr = 0;
   int   e_wr = 0, e_sd = 0, e_busy = 0, e_idx = 0, e_color = 0, e_en = 0;
   int   e_x1 = 0, e_x2 = 0, e_y1 = 0, e_y2 = 0;

   always @(posedge clk) begin
      ent_t e;
      edge_n++;
      e_wr = 0;
      e_sd = 0;
      if (!rst_b) begin
         m_active = 0; m_dwelling = 0; m_addr = 0; e_busy = 0;
         e_idx = 0; e_color = 0; e_en = 0; e_x1 = 0; e_x2 = 0; e_y1 = 0; e_y2 = 0;
      end else begin
         if (!m_active) begin
            if (run) begin
               m_active = 1; m_dwelling = 0; m_elig = edge_n + 2; e_busy = 1;
            end
         end else if (!m_dwelling && edge_n >= m_elig && !vg__stall) begin
            e = ent_t'(mtab[m_addr]);
            e_wr = 1; e_idx = int'(e.idx); e_color = int'(e.color); e_en = int'(e.en);
`ifdef RECT_SEQ_CLIP_EN
            e_x1 = mn(mn(int'(e.x1), 799), mn(int'(e.x2), 799));
            e_x2 = mx(mn(int'(e.x1), 799), mn(int'(e.x2), 799));
            e_y1 = mn(mn(int'(e.y1), 599), mn(int'(e.y2), 599));
            e_y2 = mx(mn(int'(e.y1), 599), mn(int'(e.y2), 599));
`else
            e_x1 = int'(e.x1); e_x2 = int'(e.x2); e_y1 = int'(e.y1); e_y2 = int'(e.y2);
`endif
            if (!e.last) begin
               m_addr = (m_addr + 1) % 4;
               m_elig = edge_n + 2;
            end else begin
               e_sd = 1; m_loop = e.loop; m_dwelling = 1;
               m_exit = edge_n + int'(dwell);
            end
         end
         if (m_active && m_dwelling && edge_n >= m_exit) begin
            m_addr = m_loop ? 0 : (m_addr + 1) % 4;
            m_dwelling = 0;
            if (run) m_elig = edge_n + 2;
            else begin m_active = 0; e_busy = 0; end
         end
      end
      if (tb_we) mtab[tb_addr] = tb_wdata;
   end

   // ---------------- per-cycle compare + write monitor ---------------------
   obs_t obs[$];

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rect_write", int'(vg__rect_write), e_wr);
         chk("scene_done", int'(scene_done), e_sd);
         chk("busy", int'(busy), e_busy);
         chk("cur_addr", int'(cur_addr), m_addr);
         chk("rect_index", int'(vg__rect_index), e_idx);
         chk("color", int'(st__conf_color), e_color);
         chk("enabled", int'(st__conf_enabled), e_en);
         chk("x1", int'(st__conf_rect_x1), e_x1);
         chk("x2", int'(st__conf_rect_x2), e_x2);
         chk("y1", int'(st__conf_rect_y1), e_y1);
         chk("y2", int'(st__conf_rect_y2), e_y2);
         if (vg__rect_write === 1'b1) begin
            obs.push_back('{edge_n, int'(vg__rect_index), int'(st__conf_color),
                            int'(st__conf_enabled), int'(st__conf_rect_x1),
                            int'(st__conf_rect_x2), int'(st__conf_rect_y1),
                            int'(st__conf_rect_y2), int'(scene_done), int'(cur_addr)});
         end
      end
   end

   // ---------------- directed stimulus -------------------------------------
   int t0;

   task automatic wr_tab(input int a, input logic [56:0] d);
      tb_we = 1'b1; tb_addr = 2'(a); tb_wdata = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic start_run();
      obs.delete();
      t0 = edge_n + 1;
      run = 1'b1;
   endtask

   task automatic chk_obs(input string nm, input int i, input int rel, input int idx);
      if (obs.size() > i) begin
         chk({nm, "_cycle"}, obs[i].cyc - t0, rel);
         chk({nm, "_index"}, obs[i].idx, idx);
      end else begin
         chk({nm, "_present"}, obs.size(), i + 1);
      end
   endtask

   initial begin
      rst_b = 1'b0; run = 1'b0; dwell = '0; tb_we = 1'b0; tb_addr = '0;
      tb_wdata = '0; vg__stall = 1'b0;
      repeat (3) @(negedge clk);
      cmp_en = 1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_cur_addr", int'(cur_addr), 0);
      chk("reset_write", int'(vg__rect_write), 0);
      chk("reset_x2", int'(st__conf_rect_x2), 0);
      rst_b = 1'b1;

      // Single-entry looping scene, dwell 5
      wr_tab(0, mk(1, 1, 1, 0, 8'hE0, 0, 399, 0, 299));
      dwell = 27'd5;
      start_run();
      repeat (11) @(negedge clk);
      run = 1'b0;
      chk_obs("t1_w0", 0, 2, 0);
      chk_obs("t1_w1", 1, 9, 0);
      if (obs.size() > 0) begin
         chk("t1_color", obs[0].color, 8'hE0);
         chk("t1_x2", obs[0].x2, 399);
         chk("t1_y2", obs[0].y2, 299);
         chk("t1_scene_done", obs[0].sd, 1);
      end
      repeat (10) @(negedge clk);

      // Three-entry looping scene, dwell 0
      wr_tab(0, mk(0, 0, 1, 0, 8'h11, 10, 20, 30, 40));
      wr_tab(1, mk(0, 0, 1, 1, 8'h22, 11, 21, 31, 41));
      wr_tab(2, mk(1, 1, 1, 2, 8'h33, 12, 22, 32, 42));
      dwell = 27'd0;
      start_run();
      repeat (10) @(negedge clk);
      run = 1'b0;
      chk_obs("t2_w0", 0, 2, 0);
      chk_obs("t2_w1", 1, 4, 1);
      chk_obs("t2_w2", 2, 6, 2);
      chk_obs("t2_w3", 3, 8, 0);
      if (obs.size() > 2) chk("t2_cur_after_loop", obs[2].cur, 0);
      repeat (8) @(negedge clk);

      // Stall held through four ISSUE cycles
      vg__stall = 1'b1;
      start_run();
      repeat (6) @(negedge clk);
      vg__stall = 1'b0;
      run = 1'b0;
      repeat (8) @(negedge clk);
      chk_obs("t3_w0", 0, 6, 0);
      chk("t3_writes", obs.size(), 3);
      if (obs.size() > 0) chk("t3_x1", obs[0].x1, 10);

      // run dropped during entry 1, dwell 3
      dwell = 27'd3;
      start_run();
      repeat (3) @(negedge clk);
      run = 1'b0;
      repeat (9) @(negedge clk);
      chk("t4_writes", obs.size(), 3);
      chk_obs("t4_w1", 1, 4, 1);
      chk_obs("t4_w2", 2, 6, 2);
      chk("t4_busy_end", int'(busy), 0);

      // Address wrap with last on every entry, then reset mid-dwell
      for (int i = 0; i < 4; i++) wr_tab(i, mk(0, 1, 1, i, 8'h40 + i, i, i + 1, i, i + 1));
      dwell = 27'd2;
      start_run();
      repeat (19) @(negedge clk);
      rst_b = 1'b0;
      run = 1'b0;
      @(negedge clk);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_cur", int'(cur_addr), 0);
      chk("t5_rst_color", int'(st__conf_color), 0);
      chk("t5_rst_write", int'(vg__rect_write), 0);
      rst_b = 1'b1;
      chk_obs("t5_w3", 3, 14, 3);
      chk_obs("t5_w4", 4, 18, 0);
      if (obs.size() > 3) chk("t5_cur_at3", obs[3].cur, 3);
      repeat (3) @(negedge clk);
      chk("t5_idle_after_reset", int'(busy), 0);

      // Coordinate clipping
      wr_tab(0, mk(0, 1, 1, 5, 8'h1C, 900, 100, 10, 700));
      dwell = 27'd0;
      start_run();
      repeat (3) @(negedge clk);
      run = 1'b0;
      repeat (4) @(negedge clk);
      if (obs.size() > 0) begin
`ifdef RECT_SEQ_CLIP_EN
         chk("t6_x1", obs[0].x1, 100);
         chk("t6_x2", obs[0].x2, 799);
         chk("t6_y1", obs[0].y1, 10);
         chk("t6_y2", obs[0].y2, 599);
`else
         chk("t6_x1", obs[0].x1, 900);
         chk("t6_x2", obs[0].x2, 100);
         chk("t6_y1", obs[0].y1, 10);
         chk("t6_y2", obs[0].y2, 700);
`endif
      end else begin
         chk("t6_present", obs.size(), 1);
      end

      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
